// File: rtl/sram_rw_port_arbiter_if.sv
// Bundle of the two requester ports and the SRAM macro port.
// The arbiter connects through the slave modport; the clients and the
// SRAM wrapper (or a bench standing in for them) connect through master.
interface sram_rw_port_arbiter_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned LANES  = 4
);
  // Requester 0
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [LANES-1:0]  req0_wmask;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_rvalid;
  logic [DATA_W-1:0] req0_rdata;

  // Requester 1
  logic              req1_valid;
  logic              req1_ready;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [LANES-1:0]  req1_wmask;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_rvalid;
  logic [DATA_W-1:0] req1_rdata;

  // SRAM macro RW port
  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [LANES-1:0]  sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wmask, req0_wdata,
    output req0_ready, req0_rvalid, req0_rdata,
    input  req1_valid, req1_we, req1_addr, req1_wmask, req1_wdata,
    output req1_ready, req1_rvalid, req1_rdata,
    output sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wmask, req0_wdata,
    input  req0_ready, req0_rvalid, req0_rdata,
    output req1_valid, req1_we, req1_addr, req1_wmask, req1_wdata,
    input  req1_ready, req1_rvalid, req1_rdata,
    input  sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/sram_rw_port_arbiter.sv
// Single-RW-port SRAM controller: zero-fills the array after reset, then
// round-robin shares the port between two requesters and steers the
// 1-cycle-latency read data back to whichever requester issued the read.
module sram_rw_port_arbiter #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 512
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic                    init_done_o,
  sram_rw_port_arbiter_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  // Index of the last granted requester; 1 at reset so requester 0 wins first.
  logic              rr_q, rr_d;
  // Read-owner flags: a read was accepted last cycle for that requester.
  logic              rv0_q, rv0_d;
  logic              rv1_q, rv1_d;
  logic              gnt0, gnt1;

  // State, init walk, round-robin pointer and read-owner registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      rr_q       <= 1'b1;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rr_q       <= rr_d;
      rv0_q      <= rv0_d;
      rv1_q      <= rv1_d;
    end
  end

  // Next state, grant decision and SRAM port steering.
  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    rr_d           = rr_q;
    rv0_d          = 1'b0;
    rv1_d          = 1'b0;
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    bus.sram_en    = 1'b0;
    bus.sram_wmode = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wmask = '0;
    bus.sram_wdata = '0;

    unique case (state_q)
      StInit: begin
        bus.sram_en    = 1'b1;
        bus.sram_wmode = 1'b1;
        bus.sram_addr  = init_cnt_q;
        bus.sram_wmask = '1;
        bus.sram_wdata = '0;
        if (init_cnt_q == LastAddr) begin
          state_d    = StRun;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      StRun: begin
        // On contention, grant whichever requester was not served last.
        gnt0 = bus.req0_valid & (~bus.req1_valid | rr_q);
        gnt1 = bus.req1_valid & (~bus.req0_valid | ~rr_q);
        if (gnt0) begin
          bus.sram_en    = 1'b1;
          bus.sram_wmode = bus.req0_we;
          bus.sram_addr  = bus.req0_addr;
          bus.sram_wmask = bus.req0_wmask;
          bus.sram_wdata = bus.req0_wdata;
          rv0_d          = ~bus.req0_we;
          rr_d           = 1'b0;
        end else if (gnt1) begin
          bus.sram_en    = 1'b1;
          bus.sram_wmode = bus.req1_we;
          bus.sram_addr  = bus.req1_addr;
          bus.sram_wmask = bus.req1_wmask;
          bus.sram_wdata = bus.req1_wdata;
          rv1_d          = ~bus.req1_we;
          rr_d           = 1'b1;
        end
      end
      default: state_d = StInit;
    endcase
  end

  // Handshake and read-return outputs; read data is gated to zero off-pulse.
  always_comb begin
    bus.req0_ready  = gnt0;
    bus.req1_ready  = gnt1;
    bus.req0_rvalid = rv0_q;
    bus.req1_rvalid = rv1_q;
    bus.req0_rdata  = rv0_q ? bus.sram_rdata : '0;
    bus.req1_rdata  = rv1_q ? bus.sram_rdata : '0;
  end

  assign init_done_o = (state_q == StRun);

endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// Directed bench: behavioural masked-write SRAM macro plus hand-computed
// expectations for init walk, handshakes, arbitration and read return.
module tb_sram_rw_port_arbiter;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DEPTH  = 512;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned LANES  = 4;
  localparam int unsigned LaneW  = DATA_W / LANES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_done;

  sram_rw_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES)) bus ();

  sram_rw_port_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .init_done_o (init_done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // SRAM macro model: garbage-filled on first edge, lane-masked writes,
  // registered read data.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q = '0;
  logic              filled  = 1'b0;

  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= {4{32'hDEAD_BEEF}};
      filled <= 1'b1;
    end else if (bus.sram_en) begin
      if (bus.sram_wmode) begin
        for (int l = 0; l < LANES; l++)
          if (bus.sram_wmask[l]) mem[bus.sram_addr][l*LaneW +: LaneW] <= bus.sram_wdata[l*LaneW +: LaneW];
      end else begin
        rdata_q <= mem[bus.sram_addr];
      end
    end
  end
  assign bus.sram_rdata = rdata_q;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [LANES-1:0] m, input logic [DATA_W-1:0] d);
    bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a;
    bus.req0_wmask = m; bus.req0_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [LANES-1:0] m, input logic [DATA_W-1:0] d);
    bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a;
    bus.req1_wmask = m; bus.req1_wdata = d;
  endtask

  initial begin : stim
    int cycles;
    logic [DATA_W-1:0] exp_d;
    drive0(1'b0, 1'b0, '0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0, '0);
    repeat (3) tick();

    // Reset state, with a request already pending from requester 0.
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_rvalid0", bus.req0_rvalid, 0);
    check_eq("rst_rvalid1", bus.req1_rvalid, 0);
    drive0(1'b1, 1'b0, 9'd511, 4'h0, '0);
    #1;
    check_eq("rst_ready0", bus.req0_ready, 0);
    rst = 1'b0;

    // Zero-init walk: one write per cycle, addr 0..511, requests held off.
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("init_addr", bus.sram_addr, i);
      check_eq("init_en", bus.sram_en, 1);
      check_eq("init_wmode", bus.sram_wmode, 1);
      check_eq("init_ready0", bus.req0_ready, 0);
      if (i == 0 || i == DEPTH - 1) begin
        check_eq("init_wmask", bus.sram_wmask, 4'hF);
        check_eq("init_wdata", bus.sram_wdata, 0);
        check_eq("init_done_low", init_done, 0);
      end
      tick();
    end
    check_eq("init_done_high", init_done, 1);
    check_eq("held_ready0", bus.req0_ready, 1);
    check_eq("held_addr", bus.sram_addr, 511);
    check_eq("held_wmode", bus.sram_wmode, 0);
    tick();
    drive0(1'b0, 1'b0, '0, '0, '0);
    check_eq("rd511_rvalid", bus.req0_rvalid, 1);
    check_eq("rd511_rdata", bus.req0_rdata, 0);
    tick();
    check_eq("rd511_pulse_end", bus.req0_rvalid, 0);

    // Masked write then immediate read-back of the same address.
    drive0(1'b1, 1'b1, 9'h010, 4'b0101, {4{32'hAAAA_AAAA}});
    #1;
    check_eq("wr_ready0", bus.req0_ready, 1);
    check_eq("wr_wmode", bus.sram_wmode, 1);
    check_eq("wr_wmask", bus.sram_wmask, 4'b0101);
    tick();
    check_eq("wr_no_rvalid", bus.req0_rvalid, 0);
    drive0(1'b1, 1'b0, 9'h010, 4'h0, '0);
    tick();
    drive0(1'b0, 1'b0, '0, '0, '0);
    check_eq("merge_rvalid", bus.req0_rvalid, 1);
    check_eq("merge_rdata", bus.req0_rdata, 128'h00000000_AAAAAAAA_00000000_AAAAAAAA);
    check_eq("merge_rvalid1", bus.req1_rvalid, 0);
    tick();
    check_eq("merge_rdata_off", bus.req0_rdata, 0);

    // Requester 1 alone: 4 writes then 4 back-to-back reads.
    for (int k = 1; k <= 4; k++) begin
      drive1(1'b1, 1'b1, ADDR_W'(k), 4'hF, DATA_W'(k * 'h11));
      #1;
      check_eq("r1_wr_ready", bus.req1_ready, 1);
      tick();
    end
    for (int k = 1; k <= 4; k++) begin
      drive1(1'b1, 1'b0, ADDR_W'(k), 4'h0, '0);
      #1;
      check_eq("r1_rd_ready", bus.req1_ready, 1);
      tick();
      check_eq("r1_rvalid", bus.req1_rvalid, 1);
      check_eq("r1_rdata", bus.req1_rdata, k * 'h11);
      check_eq("r1_rvalid0", bus.req0_rvalid, 0);
    end
    drive1(1'b0, 1'b0, '0, '0, '0);
    tick();
    check_eq("r1_pulse_end", bus.req1_rvalid, 0);

    // Distinct contents for the contention addresses.
    drive0(1'b1, 1'b1, 9'h020, 4'hF, 128'h2020);
    tick();
    drive0(1'b0, 1'b0, '0, '0, '0);
    drive1(1'b1, 1'b1, 9'h030, 4'hF, 128'h3030);
    tick();

    // Continuous contention: grants alternate 0,1,0,1,0,1.
    drive0(1'b1, 1'b0, 9'h020, 4'h0, '0);
    drive1(1'b1, 1'b0, 9'h030, 4'h0, '0);
    for (int c = 0; c < 6; c++) begin
      #1;
      check_eq("cont_ready0", bus.req0_ready, (c % 2) == 0);
      check_eq("cont_ready1", bus.req1_ready, (c % 2) == 1);
      check_eq("cont_en", bus.sram_en, 1);
      check_eq("cont_addr", bus.sram_addr, (c % 2) == 0 ? 9'h020 : 9'h030);
      tick();
      check_eq("cont_rvalid0", bus.req0_rvalid, (c % 2) == 0);
      check_eq("cont_rvalid1", bus.req1_rvalid, (c % 2) == 1);
      exp_d = (c % 2) == 0 ? 128'h2020 : 128'h3030;
      check_eq("cont_rdata", (c % 2) == 0 ? bus.req0_rdata : bus.req1_rdata, exp_d);
    end
    drive0(1'b0, 1'b0, '0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0, '0);
    tick();

    // Reset right after a read handshake: the response must not appear.
    drive0(1'b1, 1'b1, 9'h040, 4'hF, 128'h1234);
    tick();
    drive0(1'b1, 1'b0, 9'h040, 4'h0, '0);
    #1;
    check_eq("pre_rst_ready0", bus.req0_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    drive0(1'b0, 1'b0, '0, '0, '0);
    #1;
    check_eq("midrst_init_done", init_done, 0);
    tick();
    check_eq("midrst_no_rvalid", bus.req0_rvalid, 0);
    rst = 1'b0;
    #1;
    check_eq("reinit_addr0", bus.sram_addr, 0);

    // Interrupt the walk at counter 200 and confirm it restarts from 0.
    repeat (200) tick();
    check_eq("walk_at_200", bus.sram_addr, 200);
    rst = 1'b1;
    #1;
    check_eq("rst200_addr", bus.sram_addr, 0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("restart_addr0", bus.sram_addr, 0);
    cycles = 0;
    while (!init_done && cycles < 600) begin
      tick();
      cycles++;
    end
    check_eq("reinit_cycles", cycles, 512);

    // Previously written data is gone after re-init.
    drive0(1'b1, 1'b0, 9'h040, 4'h0, '0);
    #1;
    check_eq("post_ready0", bus.req0_ready, 1);
    tick();
    drive0(1'b1, 1'b0, 9'h010, 4'h0, '0);
    check_eq("post_rvalid_40", bus.req0_rvalid, 1);
    check_eq("post_rdata_40", bus.req0_rdata, 0);
    tick();
    drive0(1'b0, 1'b0, '0, '0, '0);
    check_eq("post_rvalid_10", bus.req0_rvalid, 1);
    check_eq("post_rdata_10", bus.req0_rdata, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
